// File: rtl/edge_wait_sequencer.sv
// edge_wait_sequencer
//   Services "wait for N matching edges" requests on a monitored signal pair and
//   returns a completion carrying sig_a's level and a cycle timestamp at the
//   completing edge. Synthesizable stand-in for @(...) event waits.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   sig_a, sig_b      monitored signal and companion (negedge source for mode 3)
//   req_valid/ready   request handshake; req_mode (0 any,1 neg,2 pos,3 pos(a)|neg(b)),
//                     req_count (0 treated as 1)
//   cancel            abandons an active wait
//   done_valid/ready  completion handshake; done_level, done_time payload
//   busy              high while waiting or holding a completion
//
// Configuration
//   EDGE_WAIT_SYNC_EN  when defined, sig_a/sig_b pass through a 2-flop synchronizer
//                      and priming waits 3 clocks so the flush never looks like an edge.
module edge_wait_sequencer #(
    parameter int CNT_W = 8,
    parameter int TS_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_a,
    input  logic             sig_b,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic [CNT_W-1:0] req_count,
    input  logic             cancel,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             done_level,
    output logic [TS_W-1:0]  done_time,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TS_W-1:0]   ts_q;
    logic              done_level_q, done_level_d;
    logic [TS_W-1:0]   done_time_q, done_time_d;
    logic              prev_a_q, prev_b_q;
    logic [1:0]        prime_cnt_q;
    logic              s_a, s_b;

    // ---------------------------------------------------------------- sampling
`ifdef EDGE_WAIT_SYNC_EN
    localparam logic [1:0] PRIME_CLKS = 2'd3;
    logic [1:0] sync_a_q, sync_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a_q <= 2'b00;
            sync_b_q <= 2'b00;
        end else begin
            sync_a_q <= {sync_a_q[0], sig_a};
            sync_b_q <= {sync_b_q[0], sig_b};
        end
    end

    assign s_a = sync_a_q[1];
    assign s_b = sync_b_q[1];
`else
    localparam logic [1:0] PRIME_CLKS = 2'd1;
    assign s_a = sig_a;
    assign s_b = sig_b;
`endif

    // Edges only count once prev_* holds a real post-reset sample; otherwise a
    // signal that is already high at release would read as a rising edge.
    logic primed;
    assign primed = (prime_cnt_q == PRIME_CLKS);

    logic rise_a, fall_a, fall_b, match;
    assign rise_a = primed &  s_a & ~prev_a_q;
    assign fall_a = primed & ~s_a &  prev_a_q;
    assign fall_b = primed & ~s_b &  prev_b_q;

    always_comb begin
        case (mode_q)
            2'd0:    match = rise_a | fall_a;
            2'd1:    match = fall_a;
            2'd2:    match = rise_a;
            default: match = rise_a | fall_b;  // coincident rise/fall is one match
        endcase
    end

    logic accept, last_hit;
    logic [CNT_W-1:0] cnt_inc;
    assign accept   = req_valid & req_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign last_hit = match & (cnt_inc == target_q);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_WAIT;
            S_WAIT: begin
                // cancel wins over a completing edge in the same cycle
                if (cancel)        state_d = S_IDLE;
                else if (last_hit) state_d = S_DONE;
            end
            S_DONE: if (done_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE) & primed & ~rst;
        done_valid = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
        done_level = done_level_q;
        done_time  = done_time_q;
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        target_d     = target_q;
        cnt_d        = cnt_q;
        done_level_d = done_level_q;
        done_time_d  = done_time_q;
        if (state_q == S_IDLE && accept) begin
            target_d = (req_count == '0) ? CNT_W'(1) : req_count;
            cnt_d    = '0;
        end else if (state_q == S_WAIT && !cancel && match) begin
            cnt_d = cnt_inc;
            if (last_hit) begin
                done_level_d = s_a;
                done_time_d  = ts_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= 2'd0;
            target_q     <= '0;
            cnt_q        <= '0;
            ts_q         <= '0;
            done_level_q <= 1'b0;
            done_time_q  <= '0;
            prev_a_q     <= 1'b0;
            prev_b_q     <= 1'b0;
            prime_cnt_q  <= 2'd0;
        end else begin
            if (state_q == S_IDLE && accept) mode_q <= req_mode;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            ts_q         <= ts_q + TS_W'(1);
            done_level_q <= done_level_d;
            done_time_q  <= done_time_d;
            prev_a_q     <= s_a;
            prev_b_q     <= s_b;
            if (!primed) prime_cnt_q <= prime_cnt_q + 2'd1;
        end
    end

endmodule

// File: tb/tb_edge_wait_sequencer.sv
module tb_edge_wait_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b1, b = 1'b1, rv = 1'b0, can = 1'b0, dr = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] cnt = 8'd0;

    logic        rr, dv, lvl, bz;
    logic [31:0] tm;
    logic        rr4, dv4, lvl4, bz4;
    logic [3:0]  tm4;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    edge_wait_sequencer #(.CNT_W(8), .TS_W(32)) dut (
        .clk(clk), .rst(rst), .sig_a(a), .sig_b(b),
        .req_valid(rv), .req_ready(rr), .req_mode(mode), .req_count(cnt),
        .cancel(can), .done_valid(dv), .done_ready(dr),
        .done_level(lvl), .done_time(tm), .busy(bz));

    // narrow timestamp copy to exercise wrap-around
    edge_wait_sequencer #(.CNT_W(8), .TS_W(4)) dut_w (
        .clk(clk), .rst(rst), .sig_a(a), .sig_b(b),
        .req_valid(rv), .req_ready(rr4), .req_mode(mode), .req_count(cnt),
        .cancel(can), .done_valid(dv4), .done_ready(dr),
        .done_level(lvl4), .done_time(tm4), .busy(bz4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    // Transaction view: count cycles since reset, delay the pins by the sampler
    // depth, and count down remaining edges of the current request.
`ifdef EDGE_WAIT_SYNC_EN
    localparam int PRIME = 3;
`else
    localparam int PRIME = 1;
`endif
    int   m_cyc, m_phase, m_rem, m_time;  // phase: 0 idle, 1 waiting, 2 holding result
    logic [1:0] m_mode;
    logic m_lvl, m_pa, m_pb;
    logic [1:0] m_ha, m_hb;               // pin history for the synchronized build

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_phase = 0; m_rem = 0; m_time = 0; m_mode = 2'd0;
            m_lvl = 1'b0; m_pa = 1'b0; m_pb = 1'b0; m_ha = 2'b00; m_hb = 2'b00;
        end else begin
            logic sa, sb, ra, fa, fb, hit, pr;
            pr = (m_cyc >= PRIME);
`ifdef EDGE_WAIT_SYNC_EN
            sa = m_ha[1]; sb = m_hb[1];
            m_ha = {m_ha[0], a}; m_hb = {m_hb[0], b};
`else
            sa = a; sb = b;
`endif
            ra = pr && sa && !m_pa;
            fa = pr && !sa && m_pa;
            fb = pr && !sb && m_pb;
            hit = (m_mode == 2'd0) ? (ra || fa) :
                  (m_mode == 2'd1) ? fa :
                  (m_mode == 2'd2) ? ra : (ra || fb);
            case (m_phase)
                0: if (rv && pr) begin
                       m_phase = 1;
                       m_mode  = mode;
                       m_rem   = (cnt == 0) ? 1 : int'(cnt);
                   end
                1: if (can) m_phase = 0;
                   else if (hit) begin
                       m_rem--;
                       if (m_rem == 0) begin
                           m_phase = 2; m_lvl = sa; m_time = m_cyc;
                       end
                   end
                default: if (dr) m_phase = 0;
            endcase
            m_pa = sa; m_pb = sb;
            m_cyc++;
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("m.req_ready",  {31'd0, rr},  {31'd0, (m_phase == 0 && m_cyc >= PRIME && !rst)});
            chk("m.done_valid", {31'd0, dv},  {31'd0, (m_phase == 2)});
            chk("m.busy",       {31'd0, bz},  {31'd0, (m_phase != 0)});
            chk("m.done_level", {31'd0, lvl}, {31'd0, m_lvl});
            chk("m.done_time",  tm,           32'(m_time));
            chk("m.done_time4", {28'd0, tm4}, 32'(m_time % 16));
            chk("m.done_valid4",{31'd0, dv4}, {31'd0, (m_phase == 2)});
        end
    end

    // ------------------------------------------------------------ directed table
    typedef struct {
        logic a, b, rv;
        logic [1:0] mode;
        logic [7:0] cnt;
        logic can, dr;
        logic rr, dv, lvl;
        int   t;
        logic bz;
    } vec_t;

    function automatic vec_t mk(logic ia, logic ib, logic irv, logic [1:0] im, logic [7:0] ic,
                                logic ican, logic idr, logic err, logic edv, logic elvl,
                                int et, logic ebz);
        vec_t v;
        v.a = ia; v.b = ib; v.rv = irv; v.mode = im; v.cnt = ic; v.can = ican; v.dr = idr;
        v.rr = err; v.dv = edv; v.lvl = elvl; v.t = et; v.bz = ebz;
        return v;
    endfunction

    task automatic cyc(input logic ia, input logic ib, input logic irv, input logic [1:0] im,
                       input logic [7:0] ic, input logic ican, input logic idr);
        a = ia; b = ib; rv = irv; mode = im; cnt = ic; can = ican; dr = idr;
        @(negedge clk);
    endtask

    vec_t tbl[25];

    initial begin
        //            a  b  rv m  cnt can dr | rr dv lvl t  bz
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0);  // high at release: no edge
        tbl[1]  = mk(1, 1, 1, 2, 1, 0, 0,  0, 0, 0, 0,  1);  // pos, count 1
        tbl[2]  = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1);
        tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1);
        tbl[4]  = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1);
        tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1);  // fall: no match
        tbl[6]  = mk(1, 1, 0, 0, 0, 0, 0,  0, 1, 1, 6,  1);  // rise completes
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 1,  1, 0, 1, 6,  0);
        tbl[8]  = mk(0, 1, 1, 0, 2, 0, 0,  0, 0, 1, 6,  1);  // fall in accept cycle ignored
        tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 6,  1);
        tbl[10] = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 6,  1);  // edge 1
        tbl[11] = mk(1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 6,  1);
        tbl[12] = mk(0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 12, 1);  // edge 2, level 0
        tbl[13] = mk(1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 12, 1);  // edge while held ignored
        tbl[14] = mk(1, 1, 0, 0, 0, 0, 1,  1, 0, 0, 12, 0);
        tbl[15] = mk(1, 1, 1, 3, 2, 0, 0,  0, 0, 0, 12, 1);  // mode 3, count 2
        tbl[16] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 12, 1);
        tbl[17] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12, 1);  // rise a + fall b = one
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12, 1);
        tbl[19] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 12, 1);
        tbl[20] = mk(1, 1, 0, 0, 0, 0, 0,  0, 1, 1, 20, 1);  // second match
        tbl[21] = mk(1, 1, 0, 0, 0, 0, 1,  1, 0, 1, 20, 0);
        tbl[22] = mk(1, 1, 1, 1, 0, 0, 0,  0, 0, 1, 20, 1);  // neg, count 0 -> 1
        tbl[23] = mk(0, 1, 0, 0, 0, 1, 0,  1, 0, 1, 20, 0);  // cancel beats completion
        tbl[24] = mk(0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 20, 0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready",  {31'd0, rr},  32'd0);
        chk("rst.done_valid", {31'd0, dv},  32'd0);
        chk("rst.busy",       {31'd0, bz},  32'd0);
        chk("rst.done_level", {31'd0, lvl}, 32'd0);
        chk("rst.done_time",  tm,           32'd0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

`ifndef EDGE_WAIT_SYNC_EN
        for (int i = 0; i < 25; i++) begin
            a = tbl[i].a; b = tbl[i].b; rv = tbl[i].rv; mode = tbl[i].mode;
            cnt = tbl[i].cnt; can = tbl[i].can; dr = tbl[i].dr;
            @(posedge clk);
            #2;
            chk($sformatf("tbl%0d.req_ready", i),  {31'd0, rr},  {31'd0, tbl[i].rr});
            chk($sformatf("tbl%0d.done_valid", i), {31'd0, dv},  {31'd0, tbl[i].dv});
            chk($sformatf("tbl%0d.done_level", i), {31'd0, lvl}, {31'd0, tbl[i].lvl});
            chk($sformatf("tbl%0d.done_time", i),  tm,           32'(tbl[i].t));
            chk($sformatf("tbl%0d.busy", i),       {31'd0, bz},  {31'd0, tbl[i].bz});
            @(negedge clk);
        end
`else
        repeat (25) cyc(a, b, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
`endif

        // completion held for 6 clocks with edges arriving; model checks stability
        cyc(0, 1, 1, 2'd0, 8'd1, 0, 0);
        repeat (3) cyc(1, 1, 0, 2'd0, 8'd0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(i[0], 1, 0, 2'd0, 8'd0, 0, 0);
        cyc(1, 1, 0, 2'd0, 8'd0, 0, 1);
        cyc(1, 1, 0, 2'd0, 8'd0, 0, 0);

        // reset in the middle of a wait clears everything immediately
        cyc(1, 1, 1, 2'd2, 8'd3, 0, 0);
        cyc(0, 1, 0, 2'd0, 8'd0, 0, 0);
        cyc(1, 1, 0, 2'd0, 8'd0, 0, 0);
        chk("wait.busy", {31'd0, bz}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst.req_ready",  {31'd0, rr},  32'd0);
        chk("arst.done_valid", {31'd0, dv},  32'd0);
        chk("arst.busy",       {31'd0, bz},  32'd0);
        chk("arst.done_level", {31'd0, lvl}, 32'd0);
        chk("arst.done_time",  tm,           32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic na, nb;
            na = ($urandom_range(0, 2) == 0) ? ~a : a;
            nb = ($urandom_range(0, 2) == 0) ? ~b : b;
            rst = ($urandom_range(0, 299) == 0);
            cyc(na, nb, ($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)),
                8'($urandom_range(0, 4)), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 2) == 0));
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
